// File: rtl/gpio_defaults_pkg.sv
// Shared definitions for the GPIO power-on configuration block.
// Contents: config word width, bit positions of each pad-control field,
// the config word type and the standard management-output config value.
package gpio_defaults_pkg;

   localparam int GPIO_CFG_W      = 13;

   localparam int CFG_MGMT_ENA    = 0;
   localparam int CFG_OEB         = 1;
   localparam int CFG_HOLD_OVR    = 2;
   localparam int CFG_INP_DIS     = 3;
   localparam int CFG_IB_MODE_SEL = 4;
   localparam int CFG_ANA_EN      = 5;
   localparam int CFG_ANA_SEL     = 6;
   localparam int CFG_ANA_POL     = 7;
   localparam int CFG_SLOW_SEL    = 8;
   localparam int CFG_VTRIP_SEL   = 9;
   localparam int CFG_DM_LSB      = 10;
   localparam int CFG_DM_MSB      = 12;

   typedef logic [GPIO_CFG_W-1:0] gpio_cfg_t;

   // Management-controlled standard output pad setting
   localparam gpio_cfg_t GPIO_CFG_MGMT_STD_OUT = 13'h1809;

endpackage

// File: rtl/gpio_cfg_shreg.sv
// 13-bit serial configuration shift register, MSB-first.
// Ports:
//   clk_sys   in   shift clock, rising edge
//   rst_b     in   async active-low reset, loads INIT
//   hold      in   1 -> register keeps its value this edge
//   data_in   in   serial bit entering at bit 0
//   shreg     out  current register contents
//   data_out  out  shreg MSB, for daisy-chaining
module gpio_cfg_shreg
   import gpio_defaults_pkg::*;
#(
   parameter logic [GPIO_CFG_W-1:0] INIT = '0
) (
   input  logic                  clk_sys,
   input  logic                  rst_b,
   input  logic                  hold,
   input  logic                  data_in,
   output logic [GPIO_CFG_W-1:0] shreg,
   output logic                  data_out
);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         shreg <= INIT;
      end else if (!hold) begin
         shreg <= {shreg[GPIO_CFG_W-2:0], data_in};
      end
   end

   assign data_out = shreg[GPIO_CFG_W-1];

endmodule

// File: rtl/gpio_defaults_block.sv
// Power-on configuration word for one GPIO pad, rewritable through a
// daisy-chained serial shift/load port, with decoded pad-control fields.
// Optional build macro GPIO_DEFAULTS_LOCK_EN adds cfg_lock, which freezes
// the config word against serial_load/default_restore (shifting continues).
// Ports:
//   serial_clock     in   sole clock, rising edge
//   resetn           in   async active-low reset, loads GPIO_CONFIG_INIT
//   serial_data_in   in   serial config bit, shifted while no load/restore
//   serial_load      in   commit shift register into config word
//   default_restore  in   reload GPIO_CONFIG_INIT (wins over serial_load)
//   cfg_lock         in   (GPIO_DEFAULTS_LOCK_EN only) freeze config word
//   serial_data_out  out  shift register MSB to next pad
//   gpio_defaults    out  registered config word
//   mgmt_ena .. dm   out  decoded fields of gpio_defaults
module gpio_defaults_block
   import gpio_defaults_pkg::*;
#(
   parameter logic [12:0] GPIO_CONFIG_INIT = 13'h0403
) (
`ifdef GPIO_DEFAULTS_LOCK_EN
   input  logic        cfg_lock,
`endif
   input  logic        serial_clock,
   input  logic        resetn,
   input  logic        serial_data_in,
   input  logic        serial_load,
   input  logic        default_restore,
   output logic        serial_data_out,
   output logic [12:0] gpio_defaults,
   output logic        mgmt_ena,
   output logic        oeb,
   output logic        hold_ovr,
   output logic        inp_dis,
   output logic        ib_mode_sel,
   output logic        ana_en,
   output logic        ana_sel,
   output logic        ana_pol,
   output logic        slow_sel,
   output logic        vtrip_sel,
   output logic [2:0]  dm
);

   logic            restore_en;
   logic            load_en;
   logic [12:0]     shreg;
   gpio_cfg_t       cfg;

`ifdef GPIO_DEFAULTS_LOCK_EN
   assign restore_en = default_restore & ~cfg_lock;
   assign load_en    = serial_load & ~cfg_lock;
`else
   assign restore_en = default_restore;
   assign load_en    = serial_load;
`endif

   // Shift only on edges where the config word is not being written; a
   // locked (ignored) load/restore therefore lets the shift proceed.
   gpio_cfg_shreg #(
      .INIT (GPIO_CONFIG_INIT)
   ) u_shreg (
      .clk_sys  (serial_clock),
      .rst_b    (resetn),
      .hold     (restore_en | load_en),
      .data_in  (serial_data_in),
      .shreg    (shreg),
      .data_out (serial_data_out)
   );

   always_ff @(posedge serial_clock or negedge resetn) begin
      if (!resetn) begin
         cfg <= GPIO_CONFIG_INIT;
      end else if (restore_en) begin
         cfg <= GPIO_CONFIG_INIT;
      end else if (load_en) begin
         cfg <= shreg;
      end
   end

   assign gpio_defaults = cfg;
   assign mgmt_ena      = cfg[CFG_MGMT_ENA];
   assign oeb           = cfg[CFG_OEB];
   assign hold_ovr      = cfg[CFG_HOLD_OVR];
   assign inp_dis       = cfg[CFG_INP_DIS];
   assign ib_mode_sel   = cfg[CFG_IB_MODE_SEL];
   assign ana_en        = cfg[CFG_ANA_EN];
   assign ana_sel       = cfg[CFG_ANA_SEL];
   assign ana_pol       = cfg[CFG_ANA_POL];
   assign slow_sel      = cfg[CFG_SLOW_SEL];
   assign vtrip_sel     = cfg[CFG_VTRIP_SEL];
   assign dm            = cfg[CFG_DM_MSB:CFG_DM_LSB];

endmodule

// File: tb/tb_gpio_defaults_block.sv
// Bench for gpio_defaults_block: four instances with different init values
// share one stimulus stream and are compared against a word-level model.
module tb_gpio_defaults_block;

   localparam int N_DUT = 4;
   localparam logic [12:0] INITS [N_DUT] = '{13'h0000, 13'h1FFF, 13'h0403, 13'h1555};

   logic serial_clock = 1'b0;
   logic clk_run      = 1'b0;
   logic resetn       = 1'b1;
   logic serial_data_in  = 1'b0;
   logic serial_load     = 1'b0;
   logic default_restore = 1'b0;
   logic cfg_lock        = 1'b0;

   logic [12:0] gd  [N_DUT];
   logic [12:0] dec [N_DUT];
   logic        sdo [N_DUT];

   int n_checks = 0;
   int n_errors = 0;

   // model state: config word and shift register per instance
   int m_cfg [N_DUT];
   int m_sh  [N_DUT];

   initial forever begin
      #5;
      if (clk_run) serial_clock = ~serial_clock;
   end

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      logic w_mgmt, w_oeb, w_hold, w_inp, w_ib, w_aen, w_asel, w_apol, w_slow, w_vtrip;
      logic [2:0] w_dm;
      gpio_defaults_block #(
         .GPIO_CONFIG_INIT (INITS[g])
      ) u_dut (
`ifdef GPIO_DEFAULTS_LOCK_EN
         .cfg_lock        (cfg_lock),
`endif
         .serial_clock    (serial_clock),
         .resetn          (resetn),
         .serial_data_in  (serial_data_in),
         .serial_load     (serial_load),
         .default_restore (default_restore),
         .serial_data_out (sdo[g]),
         .gpio_defaults   (gd[g]),
         .mgmt_ena        (w_mgmt),
         .oeb             (w_oeb),
         .hold_ovr        (w_hold),
         .inp_dis         (w_inp),
         .ib_mode_sel     (w_ib),
         .ana_en          (w_aen),
         .ana_sel         (w_asel),
         .ana_pol         (w_apol),
         .slow_sel        (w_slow),
         .vtrip_sel       (w_vtrip),
         .dm              (w_dm)
      );
      assign dec[g] = {w_dm, w_vtrip, w_slow, w_apol, w_asel, w_aen,
                       w_ib, w_inp, w_hold, w_oeb, w_mgmt};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < N_DUT; i++) begin
         chk($sformatf("%s_gd%0d", tag, i), 32'(gd[i]), m_cfg[i]);
         chk($sformatf("%s_dec%0d", tag, i), 32'(dec[i]), m_cfg[i]);
         chk($sformatf("%s_sdo%0d", tag, i), 32'(sdo[i]), (m_sh[i] >> 12) & 1);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N_DUT; i++) begin
         m_cfg[i] = int'(INITS[i]);
         m_sh[i]  = int'(INITS[i]);
      end
   endfunction

   // One clock edge: restore beats load beats shift; a locked config word
   // ignores restore/load, in which case the shift happens instead.
   function automatic void model_edge(input logic di, input logic ld, input logic rs, input logic lk);
      bit eff_rs, eff_ld;
`ifdef GPIO_DEFAULTS_LOCK_EN
      eff_rs = rs && !lk;
      eff_ld = ld && !lk;
`else
      eff_rs = rs;
      eff_ld = ld;
      if (lk) eff_rs = rs;
`endif
      for (int i = 0; i < N_DUT; i++) begin
         if (eff_rs)      m_cfg[i] = int'(INITS[i]);
         else if (eff_ld) m_cfg[i] = m_sh[i];
         else             m_sh[i]  = ((m_sh[i] * 2) + int'(di)) % 8192;
      end
   endfunction

   task automatic tick(input logic di, input logic ld, input logic rs, input string tag);
      serial_data_in  = di;
      serial_load     = ld;
      default_restore = rs;
      @(posedge serial_clock);
      model_edge(di, ld, rs, cfg_lock);
      #1;
      check_all(tag);
   endtask

   task automatic shift_word(input logic [12:0] w, input string tag);
      for (int b = 12; b >= 0; b--) tick(w[b], 1'b0, 1'b0, tag);
   endtask

   task automatic pulse_reset(input string tag);
      resetn = 1'b0;
      #2;
      model_reset();
      check_all(tag);
      resetn = 1'b1;
      #1;
   endtask

   initial begin
      logic [12:0] word;
      logic [12:0] held;
      model_reset();

      // reset with no clock running: outputs must follow init immediately
      #3;
      pulse_reset("por");
      for (int i = 0; i < N_DUT; i++) begin
         word = INITS[i];
         chk($sformatf("por_dm%0d", i), 32'(dec[i][12:10]), 32'(word[12:10]));
         chk($sformatf("por_oeb%0d", i), 32'(dec[i][1]), 32'(word[1]));
         chk($sformatf("por_mgmt%0d", i), 32'(dec[i][0]), 32'(word[0]));
      end
      check_all("idle");

      clk_run = 1'b1;

      // shift the standard management output word, then commit it
      shift_word(13'h1809, "sh1809");
      tick(1'b0, 1'b1, 1'b0, "ld1809");
      chk("load_1809", 32'(gd[2]), 32'h1809);
      chk("load_dm", 32'(dec[2][12:10]), 32'h6);

      // restore and load on the same edge: restore wins
      tick(1'b1, 1'b1, 1'b1, "restore");
      chk("restore_wins", 32'(gd[2]), 32'h0403);

      // 26-bit shift: the first word leaves serial_data_out MSB-first,
      // one bit per edge, as the downstream pad samples it on edges 14..26
      word = 13'h0ABC;
      for (int k = 0; k < 26; k++) begin
         if (k >= 13) chk($sformatf("chain_bit%0d", k - 13), 32'(sdo[2]), 32'(word[12 - (k - 13)]));
         if (k < 13) tick(word[12 - k], 1'b0, 1'b0, "chain");
         else        tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, "chain");
      end

      // reset in the middle of a shift, then load commits the init value
      for (int k = 0; k < 7; k++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, "midsh");
      pulse_reset("midrst");
      tick(1'b1, 1'b1, 1'b0, "ld_init");
      chk("ld_init_0403", 32'(gd[2]), 32'h0403);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 63) == 0) begin
            pulse_reset("rnd_rst");
         end else begin
            tick(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 15) == 0), "rnd");
         end
      end

`ifdef GPIO_DEFAULTS_LOCK_EN
      // locked: load/restore ignored, shifting continues
      held = gd[2];
      cfg_lock = 1'b1;
      shift_word(13'h1FFF, "lk_sh");
      tick(1'b1, 1'b1, 1'b0, "lk_ld");
      tick(1'b1, 1'b0, 1'b1, "lk_rs");
      chk("lock_hold", 32'(gd[2]), 32'(held));
      cfg_lock = 1'b0;
      tick(1'b0, 1'b1, 1'b0, "unlk_ld");
      chk("unlock_load", 32'(gd[2]), 32'h1FFF);
`else
      held = 13'h0;
      chk("no_lock_idle", 32'(gd[2]) | 32'(held), 32'(m_cfg[2]));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
